count_sequencer: RTL

//   Command-driven sequencer owning a WIDTH-bit up-counter (load/enable/increment datapath).

---
 rtl/count_seq_pkg.sv | 15 +
 rtl/seq_count_core.sv | 28 ++
 rtl/count_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/count_seq_pkg.sv
// Shared state encoding and default widths for the count sequencer.
package count_seq_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_REP_W = 4;
    localparam int DEF_DIV_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/seq_count_core.sv
// Counter datapath for the sequencer: loadable, enabled up-counter with a limit match flag.
module seq_count_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic             en,
    input  logic [WIDTH-1:0] v,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             match
);

    // Load has priority over increment; the increment wraps modulo 2^WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (ld) begin
            count <= v;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

    assign match = (count == limit);

endmodule

// File: rtl/count_sequencer.sv
// Job-driven count sequencer: accepts start/limit/repeat jobs and runs the counter core.
// Optional prescaler enabled by defining CNT_SEQ_PRESCALE_EN.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int REP_W = DEF_REP_W,
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic [REP_W-1:0] cmd_reps,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             pass_done,
    output logic             done,
    output logic             aborted
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] start_r;
    logic [WIDTH-1:0] limit_r;
    logic [REP_W-1:0] passes_left;
    logic             accept;
    logic             tick;
    logic             match;
    logic             pass_end;
    logic             ld;
    logic             en;

    assign accept = (state == IDLE) && cmd_valid;

`ifdef CNT_SEQ_PRESCALE_EN
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] presc;

    // Prescaler restarts from zero on every entry to RUN so each value holds div+1 clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r <= '0;
            presc <= '0;
        end else begin
            if (accept) begin
                div_r <= cmd_div;
            end
            if (state != RUN || presc == div_r) begin
                presc <= '0;
            end else begin
                presc <= presc + DIV_W'(1);
            end
        end
    end

    assign tick = (presc == div_r);
`else
    logic unused_div;
    assign unused_div = ^cmd_div;
    assign tick       = 1'b1;
`endif

    // passes_left of zero marks a continuous job and is never decremented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            start_r     <= '0;
            limit_r     <= '0;
            passes_left <= '0;
            aborted     <= 1'b0;
        end else begin
            state   <= state_next;
            aborted <= stop && (state != IDLE);
            if (accept) begin
                start_r     <= cmd_start;
                limit_r     <= cmd_limit;
                passes_left <= cmd_reps;
            end else if (pass_end && passes_left > REP_W'(1)) begin
                passes_left <= passes_left - REP_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        pass_end   = 1'b0;
        ld         = 1'b0;
        en         = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (stop) begin
                    state_next = IDLE;
                end else begin
                    ld         = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                // Stop outranks a coincident match, so no pass_done on an abort.
                if (stop) begin
                    state_next = IDLE;
                end else if (tick) begin
                    if (match) begin
                        pass_end   = 1'b1;
                        state_next = (passes_left == '0 || passes_left > REP_W'(1)) ? LOAD : DONE;
                    end else begin
                        en = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign pass_done = pass_end;

    seq_count_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (ld),
        .en    (en),
        .v     (start_r),
        .limit (limit_r),
        .count (count),
        .match (match)
    );

endmodule
